fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction prefetch queue that replaces the single IF/ID register between instruction memory and the Decode stage. It owns the fetch PC, issues sequential requests to a fixed one-cycle-latency instruction memory, and buffers up to DEPTH fetched instructions. It presents them to Decode under a valid/ready handshake, with single-cycle redirect on a taken branch or jump from Execute.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and memory address width
- DAT_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  redirect from Execute (PCSrc_E)
- target_i  in  ADDR_WIDTH  redirect address (PCTarget_E)
- imem_req_o  out  1  instruction memory read request
- imem_addr_o  out  ADDR_WIDTH  request address
- imem_rdata_i  in  DAT_WIDTH  instruction for the request issued in the previous cycle
- valid_D_o  out  1  head entry valid for Decode
- ready_D_i  in  1  Decode accepts head (IF_ID_Write)
- Ins_D  out  DAT_WIDTH  head instruction; NOP 0x0000_0013 when valid_D_o = 0
- PC_D  out  ADDR_WIDTH  head PC; 0 when invalid
- PC_4D  out  ADDR_WIDTH  PC_D + 4, modulo 2^ADDR_WIDTH; 0 when invalid

## Operation
- State:
  - pc_q: next sequential fetch address.
  - inflight_q: 1 bit; a request was issued last cycle.
  - Circular buffer: DEPTH entries of {pc, instr}.
  - rd_ptr, wr_ptr: $clog2(DEPTH) bits; wrap naturally.
  - count_q: $clog2(DEPTH)+1 bits.
  - req_pc_q: address of the in-flight request.
- pop = valid_D_o & ready_D_i & ~flush_i.
- push = inflight_q & ~flush_i. A response arriving in a flush cycle is discarded.
- Issue condition:
  - flush_i = 1: always issue.
  - Otherwise: issue when count_q + inflight_q − pop < DEPTH.
- imem_addr_o = flush_i ? target_i : pc_q. imem_req_o = issue.
- On issue: pc_q ← imem_addr_o + 4; req_pc_q ← imem_addr_o; inflight_q ← 1. Otherwise inflight_q ← 0.
- Flush:
  - Entries: count_q ← 0, rd_ptr ← wr_ptr.
  - Pop is suppressed.
  - flush_i has priority over push, pop and stall.
- Push and pop in the same cycle: count_q unchanged; both pointers advance.
- Full (count_q = DEPTH): the credit rule prevents push-on-full. A push while full is an assertion failure.
- Empty: valid_D_o = 0 and outputs show the NOP bubble, independent of ready_D_i.
- ready_D_i low holds the head stable. Fetching continues until credits are exhausted.
- Reset values:
  - pc_q = RESET_PC; inflight_q = 0; pointers 0; count_q 0.
  - valid_D_o = 0; Ins_D = NOP; PC_D = 0; PC_4D = 0.
  - imem_req_o = 1 and imem_addr_o = RESET_PC combinationally while reset is deasserted and the queue is empty.
- Assertion of rst_n mid-operation discards all entries and the in-flight response immediately.

## Timing
- Request in cycle t → data pushed at the end of t+1 → visible on valid_D_o in t+2. Latency 2 without bypass.
- Sustained throughput is 1 instr/cycle with ready_D_i held high, for any DEPTH ≥ 2.
- Redirect:
  - flush_i in cycle t → target requested in cycle t.
  - Target instruction valid at t+2 (t+1 with bypass).
  - No wrong-path instruction is ever presented after t.
- Output paths are combinational from buffer head, or from the bypass mux when compiled in. No path from ready_D_i to imem_addr_o except through the credit compare.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count_q = 0 and push, the response drives Ins_D/PC_D/valid_D_o in the same cycle.
  - If ready_D_i = 1, the entry is consumed and not written. Otherwise it is written normally.
  - Request-to-decode latency becomes 1.
- Not defined: no bypass; latency 2; outputs depend only on registered state.

## Structure
- Package fetch_pkg:
  - NOP_INSTR constant (32'h0000_0013).
  - fq_entry_t struct {pc, instr}, parametrised via the package's ADDR/DAT width localparams.
- One sub-module, fq_storage: DEPTH × fq_entry_t register array with write port and combinational read port. Pointer and count logic stay in fetch_queue.

## Test plan
- Reset release, RESET_PC = 0, ready_D_i = 1, memory returns addr|0x100 → PC_D sequence 0, 4, 8, … from cycle 2 (cycle 1 with bypass). One instr/cycle, PC_4D = PC_D + 4.
- ready_D_i = 0 for 10 cycles, DEPTH = 4:
  - imem_req_o deasserts after exactly 4 entries buffered.
  - Head held at the same PC.
  - On release: 4 buffered entries drain, then fetching resumes at 0x10 with no gap or duplicate.
- flush_i with target_i = 0x200 while 3 entries are queued and a request is in flight:
  - imem_addr_o = 0x200 in the same cycle.
  - valid_D_o low next cycle.
  - PC_D = 0x200 two cycles later; old entries never appear.
- Back-to-back flushes to 0x40 then 0x80 → only 0x80 stream appears; the 0x40 response is discarded.
- rst_n pulsed low mid-stream with queue full → outputs return to NOP/0 asynchronously; fetch restarts at RESET_PC.
- PC wrap: target_i = 0xFFFF_FFFC → PC_4D = 0x0000_0000, next fetch 0x0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Widths here set the storage entry layout used by fetch_queue.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DAT_W  = 32;

  localparam logic [DAT_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DAT_W-1:0]  instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the prefetch queue: one write port,
// one combinational read port; pointers live in the parent.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic [PW-1:0]  waddr_i,
  input  fq_entry_t      wdata_i,
  input  logic [PW-1:0]  raddr_i,
  output fq_entry_t      rdata_o
);

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue between imem and Decode with redirect.
// Define FETCH_QUEUE_BYPASS_EN to forward a response into an empty queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DAT_WIDTH-1:0]  imem_rdata_i,
  output logic                  valid_D_o,
  input  logic                  ready_D_i,
  output logic [DAT_WIDTH-1:0]  Ins_D,
  output logic [ADDR_WIDTH-1:0] PC_D,
  output logic [ADDR_WIDTH-1:0] PC_4D
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic      empty, push, pop, deq, wr_en, issue, byp, valid;
  logic [CW:0] credit;
  fq_entry_t head, wentry, sel;

  assign empty = (count_q == '0);
  assign push  = inflight_q & ~flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & push;
`else
  assign byp = 1'b0;
`endif

  assign valid = ~empty | byp;
  assign pop   = valid & ready_D_i & ~flush_i;
  assign deq   = pop & ~empty;
  // A bypassed response consumed this cycle never enters storage.
  assign wr_en = push & ~(byp & ready_D_i);

  assign credit = {1'b0, count_q}
                + {{CW{1'b0}}, inflight_q}
                - {{CW{1'b0}}, pop};
  assign issue  = flush_i | (credit < CAP);

  assign imem_req_o  = issue;
  assign imem_addr_o = flush_i ? target_i : pc_q;

  assign wentry = '{pc: req_pc_q, instr: imem_rdata_i};
  assign sel    = byp ? wentry : head;

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wentry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    valid_D_o = valid;
    Ins_D     = NOP_INSTR;
    PC_D      = '0;
    PC_4D     = '0;
    if (valid) begin
      Ins_D = sel.instr;
      PC_D  = sel.pc;
      PC_4D = sel.pc + ADDR_WIDTH'(4);
    end
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (issue) begin
      pc_d     = imem_addr_o + ADDR_WIDTH'(4);
      req_pc_d = imem_addr_o;
    end
    rd_ptr_d = rd_ptr_q + PW'(deq);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    count_d  = count_q + CW'(wr_en) - CW'(deq);
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(wr_en && count_q == FULL)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected PCs are queued by
// the stimulus and checked by a monitor on every Decode accept.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_D_o;
  logic        ready_D_i = 1'b0;
  logic [31:0] Ins_D;
  logic [31:0] PC_D;
  logic [31:0] PC_4D;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int accepted = 0;
  int mark_cyc = -1;
  logic [31:0] mark_pc = '0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
  localparam logic [31:0] HELD = 32'h14;
  localparam int STALL_REQS = 3;
`else
  localparam int LAT = 2;
  localparam logic [31:0] HELD = 32'h10;
  localparam int STALL_REQS = 2;
`endif

  fetch_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .target_i     (target_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .valid_D_o    (valid_D_o),
    .ready_D_i    (ready_D_i),
    .Ins_D        (Ins_D),
    .PC_D         (PC_D),
    .PC_4D        (PC_4D)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    imem_rdata_i <= imem_addr_o | 32'h100;
  end

  always @(negedge clk) begin
    if (rst_n && valid_D_o && ready_D_i && !flush_i) begin
      accepted++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL accept_unexpected: got pc %h, want none", PC_D);
      end else begin
        e = exp_q.pop_front();
        if (PC_D !== e || Ins_D !== (e | 32'h100)
            || PC_4D !== e + 32'd4) begin
          n_fail++;
          $display("FAIL accept: got pc %h ins %h pc4 %h, want %h %h %h",
                   PC_D, Ins_D, PC_4D, e, e | 32'h100, e + 32'd4);
        end
      end
      if (PC_D === mark_pc && mark_cyc < 0) mark_cyc = cyc;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_stream(logic [31:0] start, logic [31:0] mark);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    mark_pc  = mark;
    mark_cyc = -1;
  endtask

  int base, nreq, fcyc;

  initial begin
    #12;
    chk("rst_valid", 32'(valid_D_o), 32'd0);
    chk("rst_ins", Ins_D, 32'h0000_0013);
    chk("rst_pc", PC_D, 32'd0);
    chk("rst_pc4", PC_4D, 32'd0);

    expect_stream(32'h0, 32'h0);
    rst_n = 1'b1;
    ready_D_i = 1'b1;
    fcyc = cyc;
    #1;
    chk("boot_req", 32'(imem_req_o), 32'd1);
    chk("boot_addr", imem_addr_o, 32'h0);
    step(6);
    chk("boot_latency", 32'(mark_cyc - fcyc), 32'(LAT));

    ready_D_i = 1'b0;
    nreq = 0;
    repeat (10) begin
      #2;
      nreq += int'(imem_req_o);
      chk("stall_head", PC_D, HELD);
      @(posedge clk);
      #1;
    end
    chk("stall_reqs", 32'(nreq), 32'(STALL_REQS));
    chk("stall_req_low", 32'(imem_req_o), 32'd0);
    chk("stall_valid", 32'(valid_D_o), 32'd1);

    ready_D_i = 1'b1;
    base = accepted;
    step(12);
    chk("throughput", 32'(accepted - base), 32'd12);

    ready_D_i = 1'b0;
    step(2);
    ready_D_i = 1'b1;
    flush_i = 1'b1;
    target_i = 32'h200;
    expect_stream(32'h200, 32'h200);
    fcyc = cyc;
    #1;
    chk("flush_addr", imem_addr_o, 32'h200);
    chk("flush_req", 32'(imem_req_o), 32'd1);
    step(1);
    flush_i = 1'b0;
`ifndef FETCH_QUEUE_BYPASS_EN
    #1;
    chk("flush_bubble", 32'(valid_D_o), 32'd0);
`endif
    step(4);
    chk("flush_latency", 32'(mark_cyc - fcyc), 32'(LAT));

    flush_i = 1'b1;
    target_i = 32'h40;
    step(1);
    target_i = 32'h80;
    expect_stream(32'h80, 32'h80);
    fcyc = cyc;
    #1;
    chk("b2b_addr", imem_addr_o, 32'h80);
    step(1);
    flush_i = 1'b0;
    step(5);
    chk("b2b_latency", 32'(mark_cyc - fcyc), 32'(LAT));

    ready_D_i = 1'b0;
    step(8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_D_o), 32'd0);
    chk("arst_ins", Ins_D, 32'h0000_0013);
    chk("arst_pc", PC_D, 32'd0);
    chk("arst_pc4", PC_4D, 32'd0);
    expect_stream(32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_D_i = 1'b1;
    fcyc = cyc;
    #1;
    chk("restart_addr", imem_addr_o, 32'h0);
    step(5);
    chk("restart_latency", 32'(mark_cyc - fcyc), 32'(LAT));

    flush_i = 1'b1;
    target_i = 32'hFFFF_FFFC;
    expect_stream(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fcyc = cyc;
    step(1);
    flush_i = 1'b0;
    #1;
    chk("wrap_next_addr", imem_addr_o, 32'h0);
    chk("wrap_next_req", 32'(imem_req_o), 32'd1);
    step(6);
    chk("wrap_latency", 32'(mark_cyc - fcyc), 32'(LAT));

    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
